// File: rtl/stage_2_multibool_if.sv
// Stage-2 transaction bus: stage-1 operands and handshake in, per-lane encode beat out.
interface stage_2_multibool_if #(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5,
    parameter int MAX_BOOL    = 8,
    parameter int BOOL_LANES  = 3,
    parameter int CNT_WIDTH   = $clog2(MAX_BOOL + 1)
);
    logic                              in_valid;
    logic                              in_ready;
    logic                              in_bool;
    logic [CNT_WIDTH-1:0]              in_num_bool;
    logic [MAX_BOOL-1:0]               in_symbols;
    logic [RANGE_WIDTH-1:0]            in_range;
    logic [RANGE_WIDTH-1:0]            UU;
    logic [RANGE_WIDTH-1:0]            VV;
    logic [RANGE_WIDTH-1:0]            lut_u;
    logic [RANGE_WIDTH-1:0]            lut_v;
    logic [RANGE_WIDTH-1:0]            lut_uv;
    logic                              comp_mux;

    logic                              out_valid;
    logic                              out_last;
    logic                              out_bool;
    logic                              out_comp_mux;
    logic [BOOL_LANES-1:0]             out_lane_valid;
    logic [BOOL_LANES-1:0]             out_symbol;
    logic [BOOL_LANES*D_SIZE-1:0]      out_d;
    logic [BOOL_LANES*RANGE_WIDTH-1:0] out_pre_low;
    logic [BOOL_LANES*RANGE_WIDTH-1:0] out_init_range;
    logic [RANGE_WIDTH:0]              out_u;
    logic [RANGE_WIDTH-1:0]            out_range;

    modport master (
        output in_valid, in_bool, in_num_bool, in_symbols, in_range,
               UU, VV, lut_u, lut_v, lut_uv, comp_mux,
        input  in_ready, out_valid, out_last, out_bool, out_comp_mux, out_lane_valid,
               out_symbol, out_d, out_pre_low, out_init_range, out_u, out_range
    );

    modport slave (
        input  in_valid, in_bool, in_num_bool, in_symbols, in_range,
               UU, VV, lut_u, lut_v, lut_uv, comp_mux,
        output in_ready, out_valid, out_last, out_bool, out_comp_mux, out_lane_valid,
               out_symbol, out_d, out_pre_low, out_init_range, out_u, out_range
    );
endinterface

// File: rtl/stage_2_multibool.sv
// Stage-2 encode/renormalization: one CDF symbol or a burst of 50% Booleans,
// BOOL_LANES Booleans per beat through a chained lane cascade.
//   state | meaning
//   IDLE  | ready; accepts a CDF symbol or the first beat of a Boolean burst
//   BUSY  | emitting further beats of a burst from range_q / sym_q / rem_q
module stage_2_multibool #(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int SYMBOL_WIDTH = 4,
    parameter int MAX_BOOL     = 8,
    parameter int BOOL_LANES   = 3,
    parameter int CNT_WIDTH    = $clog2(MAX_BOOL + 1)
) (
    input  logic               clk,
    input  logic               reset,
    stage_2_multibool_if.slave bus
);
    localparam int RW = RANGE_WIDTH;
    localparam int PW = 2 * RANGE_WIDTH;
    localparam int LRW = BOOL_LANES * RANGE_WIDTH;
    localparam int LDW = BOOL_LANES * D_SIZE;
    localparam logic [CNT_WIDTH-1:0] LanesC = CNT_WIDTH'(BOOL_LANES);
    localparam logic [CNT_WIDTH-1:0] MaxC   = CNT_WIDTH'(MAX_BOOL);
    // Only the symbol LSB reaches the Boolean lanes.
    localparam logic SymMask = (SYMBOL_WIDTH >= 1);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t                state_q;
    logic [RW-1:0]         range_q;
    logic [MAX_BOOL-1:0]   sym_q;
    logic [CNT_WIDTH-1:0]  rem_q;

    logic                  valid_q, last_q, bool_q, comp_q;
    logic [BOOL_LANES-1:0] lane_valid_q, symbol_q;
    logic [LDW-1:0]        d_q;
    logic [LRW-1:0]        pre_low_q, init_range_q;
    logic [RW:0]           u_q;
    logic [RW-1:0]         out_range_q;

    function automatic logic [D_SIZE-1:0] lzc(input logic [RW-1:0] x);
        logic [D_SIZE-1:0] c;
        logic              found;
        c = '0;
        found = 1'b0;
        for (int i = RW - 1; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else      c = c + D_SIZE'(1);
            end
        end
        return found ? c : '0;
    endfunction

    logic                 busy, beat_cdf, beat_bool, beat_last;
    logic [CNT_WIDTH-1:0] n_eff, cnt_sel;
    logic [RW-1:0]        base_range;
    logic [MAX_BOOL-1:0]  syms_sel;

    assign busy       = (state_q == BUSY);
    assign n_eff      = (bus.in_num_bool == '0) ? CNT_WIDTH'(1) :
                        (bus.in_num_bool > MaxC) ? MaxC : bus.in_num_bool;
    assign cnt_sel    = busy ? rem_q : n_eff;
    assign base_range = busy ? range_q : bus.in_range;
    assign syms_sel   = (busy ? sym_q : bus.in_symbols) & {MAX_BOOL{SymMask}};
    assign beat_cdf   = !busy && bus.in_valid && !bus.in_bool;
    assign beat_bool  = busy || (bus.in_valid && bus.in_bool);
    assign beat_last  = (cnt_sel <= LanesC);

    logic [RW-1:0]   rr, cdf_v, cdf_r1, cdf_r2, cdf_raw, cdf_range;
    logic [RW:0]     cdf_tu, cdf_u;
    logic [D_SIZE-1:0] cdf_d;

    assign rr        = bus.in_range >> 8;
    assign cdf_tu    = (RW+1)'((PW'(rr) * PW'(bus.UU)) >> 1);
    assign cdf_u     = cdf_tu + (RW+1)'(bus.lut_u);
    assign cdf_v     = RW'((PW'(rr) * PW'(bus.VV)) >> 1);
    assign cdf_r1    = cdf_tu[RW-1:0] - cdf_v + bus.lut_uv;
    assign cdf_r2    = bus.in_range - bus.lut_v - cdf_v;
    assign cdf_raw   = bus.comp_mux ? cdf_r1 : cdf_r2;
    assign cdf_d     = lzc(cdf_raw);
    assign cdf_range = cdf_raw << cdf_d;

    logic [BOOL_LANES-1:0] bl_valid_d, bl_sym_d;
    logic [LDW-1:0]        bl_d_d;
    logic [LRW-1:0]        bl_pre_d, bl_init_d;
    logic [RW-1:0]         bl_range_d;

    // Inactive lanes pass the range through, so the chain end is the last active lane's output.
    always_comb begin
        logic [RW-1:0] r, v, pre, raw;
        logic [1:0]    dd;
        r = base_range;
        v = '0;
        pre = '0;
        raw = '0;
        dd = '0;
        bl_valid_d = '0;
        bl_sym_d   = '0;
        bl_d_d     = '0;
        bl_pre_d   = '0;
        bl_init_d  = '0;
        for (int k = 0; k < BOOL_LANES; k++) begin
            if (k < int'(cnt_sel)) begin
                v   = ((r >> 8) << 7) + RW'(4);
                pre = r - v;
                raw = syms_sel[k] ? v : pre;
                dd  = raw[RW-1] ? 2'd0 : (raw[RW-2] ? 2'd1 : 2'd2);
                bl_valid_d[k]               = 1'b1;
                bl_sym_d[k]                 = syms_sel[k];
                bl_d_d[k*D_SIZE +: D_SIZE]  = D_SIZE'(dd);
                bl_pre_d[k*RW +: RW]        = pre;
                bl_init_d[k*RW +: RW]       = r;
                r = raw << dd;
            end
        end
        bl_range_d = r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            range_q      <= '0;
            sym_q        <= '0;
            rem_q        <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            bool_q       <= 1'b0;
            comp_q       <= 1'b0;
            lane_valid_q <= '0;
            symbol_q     <= '0;
            d_q          <= '0;
            pre_low_q    <= '0;
            init_range_q <= '0;
            u_q          <= '0;
            out_range_q  <= '0;
        end else begin
            valid_q <= beat_cdf || beat_bool;
            if (beat_cdf) begin
                last_q       <= 1'b1;
                bool_q       <= 1'b0;
                comp_q       <= bus.comp_mux;
                lane_valid_q <= BOOL_LANES'(1);
                symbol_q     <= '0;
                d_q          <= LDW'(cdf_d);
                pre_low_q    <= '0;
                init_range_q <= LRW'(bus.in_range);
                u_q          <= cdf_u;
                out_range_q  <= cdf_range;
            end else if (beat_bool) begin
                last_q       <= beat_last;
                bool_q       <= 1'b1;
                comp_q       <= 1'b0;
                lane_valid_q <= bl_valid_d;
                symbol_q     <= bl_sym_d;
                d_q          <= bl_d_d;
                pre_low_q    <= bl_pre_d;
                init_range_q <= bl_init_d;
                u_q          <= '0;
                out_range_q  <= bl_range_d;
                if (beat_last) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= BUSY;
                    sym_q   <= syms_sel >> BOOL_LANES;
                    rem_q   <= cnt_sel - LanesC;
                    range_q <= bl_range_d;
                end
            end
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = valid_q;
    assign bus.out_last       = last_q;
    assign bus.out_bool       = bool_q;
    assign bus.out_comp_mux   = comp_q;
    assign bus.out_lane_valid = lane_valid_q;
    assign bus.out_symbol     = symbol_q;
    assign bus.out_d          = d_q;
    assign bus.out_pre_low    = pre_low_q;
    assign bus.out_init_range = init_range_q;
    assign bus.out_u          = u_q;
    assign bus.out_range      = out_range_q;
endmodule

// File: tb/tb_stage_2_multibool.sv
// Directed bench for stage_2_multibool: reset, Boolean beats, CDF beats, bursts, back-to-back.
module tb_stage_2_multibool;
    localparam int RW = 16;
    localparam int DS = 5;
    localparam int MB = 8;
    localparam int BL = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stage_2_multibool_if #(.RANGE_WIDTH(RW), .D_SIZE(DS), .MAX_BOOL(MB),
                           .BOOL_LANES(BL), .CNT_WIDTH(CW)) bus();

    stage_2_multibool #(.RANGE_WIDTH(RW), .D_SIZE(DS), .SYMBOL_WIDTH(4), .MAX_BOOL(MB),
                        .BOOL_LANES(BL), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_bool     = 1'b0;
        bus.in_num_bool = '0;
        bus.in_symbols  = '0;
        bus.in_range    = '0;
        bus.UU          = '0;
        bus.VV          = '0;
        bus.lut_u       = '0;
        bus.lut_v       = '0;
        bus.lut_uv      = '0;
        bus.comp_mux    = 1'b0;
    endtask

    task automatic drive_bool(input logic [CW-1:0] num, input logic [MB-1:0] syms,
                              input logic [RW-1:0] r);
        bus.in_valid    = 1'b1;
        bus.in_bool     = 1'b1;
        bus.in_num_bool = num;
        bus.in_symbols  = syms;
        bus.in_range    = r;
    endtask

    task automatic drive_cdf(input logic comp, input logic [RW-1:0] lv);
        bus.in_valid = 1'b1;
        bus.in_bool  = 1'b0;
        bus.in_range = 16'h8000;
        bus.UU       = 16'd256;
        bus.VV       = 16'd128;
        bus.lut_u    = 16'd4;
        bus.lut_uv   = 16'd4;
        bus.lut_v    = lv;
        bus.comp_mux = comp;
    endtask

    // Reference lane: v = floor(r/256)*128 + 4, then double until normalized, at most twice.
    function automatic void model_lane(input logic [RW-1:0] r, input logic s,
                                       output logic [RW-1:0] o, output logic [DS-1:0] d,
                                       output logic [RW-1:0] pre);
        int unsigned v;
        logic [RW-1:0] x;
        v   = (int'(r) / 256) * 128 + 4;
        pre = RW'(int'(r) - int'(v));
        x   = s ? RW'(v) : pre;
        d   = '0;
        while (d < 2 && x < 16'h8000) begin
            x = RW'({x, 1'b0});
            d = d + 1'b1;
        end
        o = x;
    endfunction

    task automatic expect_bool_beat(input string tag, input logic [RW-1:0] base,
                                    input logic [MB-1:0] syms, input int nl,
                                    input logic last, output logic [RW-1:0] rout);
        logic [BL-1:0]    ev, es;
        logic [BL*DS-1:0] ed;
        logic [BL*RW-1:0] ep, ei;
        logic [RW-1:0]    r, o, p;
        logic [DS-1:0]    d;
        ev = '0; es = '0; ed = '0; ep = '0; ei = '0;
        r = base;
        for (int k = 0; k < nl; k++) begin
            ev[k] = 1'b1;
            es[k] = syms[k];
            ei[k*RW +: RW] = r;
            model_lane(r, syms[k], o, d, p);
            ed[k*DS +: DS] = d;
            ep[k*RW +: RW] = p;
            r = o;
        end
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_last"}, bus.out_last, last);
        check({tag, "_bool"}, bus.out_bool, 1'b1);
        check({tag, "_lanes"}, bus.out_lane_valid, ev);
        check({tag, "_sym"}, bus.out_symbol, es);
        check({tag, "_d"}, bus.out_d, ed);
        check({tag, "_prelow"}, bus.out_pre_low, ep);
        check({tag, "_init"}, bus.out_init_range, ei);
        check({tag, "_range"}, bus.out_range, r);
        check({tag, "_u"}, bus.out_u, 0);
        rout = r;
    endtask

    logic [RW-1:0] r_next;

    initial begin
        reset = 1'b1;
        idle_inputs();
        drive_bool(4'd5, 8'hA5, 16'h1234);
        bus.UU = 16'h7777;
        bus.comp_mux = 1'b1;
        step();
        step();
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_lanes", bus.out_lane_valid, 0);
        check("rst_d", bus.out_d, 0);
        check("rst_init", bus.out_init_range, 0);
        check("rst_u", bus.out_u, 0);
        check("rst_range", bus.out_range, 0);
        check("rst_ready", bus.in_ready, 1);
        reset = 1'b0;
        idle_inputs();
        step();
        check("idle_valid", bus.out_valid, 0);

        // Single Booleans from 0x8000, hand values first.
        drive_bool(4'd1, 8'h00, 16'h8000);
        step();
        idle_inputs();
        check("b1s0_hand_range", bus.out_range, 16'd65520);
        check("b1s0_hand_d", bus.out_d, 2);
        check("b1s0_hand_pre", bus.out_pre_low, 16380);
        expect_bool_beat("b1s0", 16'h8000, 8'h00, 1, 1'b1, r_next);

        drive_bool(4'd1, 8'h01, 16'h8000);
        step();
        idle_inputs();
        check("b1s1_hand_range", bus.out_range, 16'd32776);
        check("b1s1_hand_d", bus.out_d, 1);
        expect_bool_beat("b1s1", 16'h8000, 8'h01, 1, 1'b1, r_next);

        drive_bool(4'd3, 8'h07, 16'h8000);
        step();
        idle_inputs();
        check("b3_hand_d", bus.out_d, {5'd1, 5'd1, 5'd1});
        check("b3_hand_init", bus.out_init_range, {16'd32776, 16'd32776, 16'd32768});
        check("b3_hand_range", bus.out_range, 16'd32776);
        check("b3_hand_ready", bus.in_ready, 1);
        expect_bool_beat("b3", 16'h8000, 8'h07, 3, 1'b1, r_next);

        // CDF beats on both compare paths.
        drive_cdf(1'b1, 16'd0);
        step();
        idle_inputs();
        check("cdf1_valid", bus.out_valid, 1);
        check("cdf1_last", bus.out_last, 1);
        check("cdf1_bool", bus.out_bool, 0);
        check("cdf1_comp", bus.out_comp_mux, 1);
        check("cdf1_lanes", bus.out_lane_valid, 3'b001);
        check("cdf1_u", bus.out_u, 17'd16388);
        check("cdf1_d", bus.out_d, 2);
        check("cdf1_range", bus.out_range, 16'd32784);
        drive_cdf(1'b0, 16'd4);
        step();
        idle_inputs();
        check("cdf0_comp", bus.out_comp_mux, 0);
        check("cdf0_d", bus.out_d, 1);
        check("cdf0_range", bus.out_range, 16'd49144);
        step();
        check("gap_valid", bus.out_valid, 0);
        check("gap_hold_range", bus.out_range, 16'd49144);

        // n=7 burst; in_valid stays high (as a CDF) during BUSY and must be ignored.
        drive_bool(4'd7, 8'b1011_0010, 16'h9A3C);
        step();
        drive_cdf(1'b1, 16'd0);
        expect_bool_beat("b7_0", 16'h9A3C, 8'b1011_0010, 3, 1'b0, r_next);
        check("b7_0_ready", bus.in_ready, 0);
        step();
        expect_bool_beat("b7_1", r_next, 8'b1011_0010 >> 3, 3, 1'b0, r_next);
        check("b7_1_ready", bus.in_ready, 0);
        step();
        idle_inputs();
        expect_bool_beat("b7_2", r_next, 8'b1011_0010 >> 6, 1, 1'b1, r_next);
        check("b7_2_ready", bus.in_ready, 1);
        step();
        check("b7_after_valid", bus.out_valid, 0);

        // Count 0 behaves as 1.
        drive_bool(4'd0, 8'h01, 16'h4567);
        step();
        idle_inputs();
        expect_bool_beat("n0", 16'h4567, 8'h01, 1, 1'b1, r_next);

        // Count 15 clamps to 8, then a CDF is accepted straight after the last beat.
        drive_bool(4'd15, 8'b0110_1001, 16'hC123);
        step();
        idle_inputs();
        expect_bool_beat("n15_0", 16'hC123, 8'b0110_1001, 3, 1'b0, r_next);
        step();
        expect_bool_beat("n15_1", r_next, 8'b0110_1001 >> 3, 3, 1'b0, r_next);
        step();
        expect_bool_beat("n15_2", r_next, 8'b0110_1001 >> 6, 2, 1'b1, r_next);
        drive_cdf(1'b1, 16'd0);
        step();
        idle_inputs();
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_bool", bus.out_bool, 0);
        check("b2b_range", bus.out_range, 16'd32784);

        // Reset in the middle of a burst abandons it.
        drive_bool(4'd8, 8'hFF, 16'h8000);
        step();
        idle_inputs();
        expect_bool_beat("rb_0", 16'h8000, 8'hFF, 3, 1'b0, r_next);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rb_valid", bus.out_valid, 0);
        check("rb_ready", bus.in_ready, 1);
        check("rb_range", bus.out_range, 0);
        check("rb_lanes", bus.out_lane_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rb_quiet_valid", bus.out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stage_2_multibool.md
Name: stage_2_multibool

Overview:
- Parametrised, registered successor of the stage-2 encode/renormalization datapath.
- Finishes the Q15 encoding step for either one CDF symbol or a burst of up to MAX_BOOL 50%-probability Booleans.
- Processes BOOL_LANES Booleans per cycle as a chained combinational lane cascade. Bursts longer than BOOL_LANES are spread over several cycles by a small FSM with an input handshake.
- Sits between stage 1 (UU/VV/LUT pre-calc) and stage 3 (low update / carry). Each output beat is one stage-3 transaction.

Parameters:
- RANGE_WIDTH, 16, range/low datapath width
- D_SIZE, 5, renormalization shift width
- SYMBOL_WIDTH, 4, symbol width; only the LSB is used for Booleans
- MAX_BOOL, 8, maximum Booleans per accepted burst
- BOOL_LANES, 3, Booleans processed per cycle; 1 <= BOOL_LANES <= MAX_BOOL
- CNT_WIDTH, $clog2(MAX_BOOL+1), burst count width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept; combinational, equals (state==IDLE)
- in_bool  in  1  1=Boolean burst, 0=CDF symbol
- in_num_bool  in  CNT_WIDTH  Booleans in burst
- in_symbols  in  MAX_BOOL  Boolean symbol LSBs; bit 0 is encoded first
- in_range  in  RANGE_WIDTH  current range
- UU, VV, lut_u, lut_v, lut_uv  in  RANGE_WIDTH each  stage-1 CDF operands
- comp_mux  in  1  CDF select: 1=u-v path, 0=range-v path
- out_valid  out  1  output beat valid
- out_last  out  1  final beat of the transaction
- out_bool  out  1  beat is Boolean
- out_comp_mux  out  1  registered comp_mux (CDF beats)
- out_lane_valid  out  BOOL_LANES  active lanes; CDF beat = lane 0 only
- out_symbol  out  BOOL_LANES  per-lane symbol LSB
- out_d  out  BOOL_LANES*D_SIZE  per-lane shift; lane 0 carries the CDF d
- out_pre_low  out  BOOL_LANES*RANGE_WIDTH  per-lane r-v (Boolean low pre-calc)
- out_init_range  out  BOOL_LANES*RANGE_WIDTH  per-lane range before encoding
- out_u  out  RANGE_WIDTH+1  CDF u; 0 on Boolean beats
- out_range  out  RANGE_WIDTH  normalized range after the last active lane

Behaviour:
- All outputs are registered, with 1-cycle latency from acceptance or BUSY step. Packed lane k occupies bits [k*W +: W].
- Reset (sync, dominant over all else): state=IDLE; all outputs 0; internal range_q, remaining count and symbol shift register cleared. Reset mid-BUSY abandons the burst with no partial beats. in_ready=1 in the cycle after reset.
- Acceptance occurs when in_valid & in_ready. in_valid while BUSY is ignored; no beat is produced for it.
- CDF arithmetic:
  - RR = in_range>>8; tu = (RR*UU)>>1 (17b); u = tu+lut_u; v = (RR*VV)>>1.
  - r1 = tu[15:0]-v[15:0]+lut_uv; r2 = in_range-lut_v-v[15:0]; all mod 2^RANGE_WIDTH.
  - raw = comp_mux ? r1 : r2; d = leading-zero count of raw; range = raw<<d.
  - raw==0 is illegal; it must produce d=0, range=0.
- Boolean lane arithmetic (input r):
  - v = ((r>>8)<<7)+4; pre_low = r-v; raw = sym ? v : pre_low.
  - d = raw[MSB] ? 0 : raw[MSB-1] ? 1 : 2; out = raw<<d.
- Lane k input is lane k-1 output; lane 0 input is in_range (IDLE) or range_q (BUSY).
- Effective count n = in_num_bool, with 0 treated as 1 and values above MAX_BOOL clamped to MAX_BOOL.
- Inactive lanes: lane_valid=0, d=0, pre_low=0, init_range=0, symbol=0.
- out_range is the output of the highest active lane.
- FSM, IDLE:
  - On accepted CDF: emit CDF beat, out_last=1, stay IDLE.
  - On accepted Boolean burst: run min(n,BOOL_LANES) lanes.
    - If n <= BOOL_LANES: out_last=1, stay IDLE.
    - Else: store the remaining symbols shifted down, rem = n-BOOL_LANES, range_q = beat out_range; go BUSY.
- FSM, BUSY: each cycle run min(rem,BOOL_LANES) lanes from range_q, emit a beat and update range_q/rem. When rem <= BOOL_LANES: out_last=1, go IDLE.
- A new transaction can be accepted in the cycle out_last is registered, giving back-to-back throughput.
- out_valid=0 in any cycle with no acceptance and no BUSY step. Other outputs hold their last values.

Test Plan:
- Reset with arbitrary inputs -> next cycle all outputs 0, in_ready=1. Assert reset mid-BUSY -> IDLE, out_valid=0, no further beats.
- Boolean n=1, in_range=0x8000, sym=0 -> pre_low=16380, d0=2, out_range=65520. With sym=1 -> d0=1, out_range=32776. Both beats: out_last=1.
- Boolean n=3, BOOL_LANES=3, in_range=0x8000, syms=111 -> one beat: lane_valid=111, d=1,1,1, init_range=32768,32776,32776, out_range=32776.
- CDF: in_range=0x8000, UU=256, VV=128, lut_u=4, lut_uv=4, lut_v=0, comp=1 -> u=16388, raw=8196, d=2, out_range=32784. Same with comp=0, lut_v=4 -> raw=24572, d=1, out_range=49144.
- MAX_BOOL=8, BOOL_LANES=3, n=7 -> three consecutive beats with lane_valid 111,111,001 and in_ready low for 2 cycles. Lane-0 range of beats 2 and 3 equals the prior beat's out_range. out_last only on beat 3. in_valid held during BUSY is ignored.
- in_num_bool=0 and in_num_bool=15 -> processed as 1 and 8 Booleans respectively. A CDF accepted in the same cycle the Boolean out_last is registered -> emitted next cycle with no bubble.
